// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment driver: shadowed BCD digits scanned onto one segment bus.
// Registered outputs, one edge behind state; leading-zero suppression, per-digit blanking, whole-display blink.
module seg_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int BLINK_DIV  = 500000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_bcd,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic                    lz_suppress,
  input  logic                    blink_en,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SCAN_W  = (SCAN_DIV > 1)   ? $clog2(SCAN_DIV)   : 1;
  localparam int BLINK_W = (BLINK_DIV > 1)  ? $clog2(BLINK_DIV)  : 1;

  localparam logic [6:0]            SEG_OFF = {7{ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{ACTIVE_LOW}};

  logic [SCAN_W-1:0]       presc_q, presc_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [BLINK_W-1:0]      blink_cnt_q, blink_cnt_d;
  logic                    phase_q, phase_d;
  logic [4*NUM_DIGITS-1:0] dig_q, dig_d;
  logic [NUM_DIGITS-1:0]   blank_q, blank_d;
  logic                    lz_q, lz_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;

  logic [NUM_DIGITS-1:0]   lz_dark;
  logic                    zeros_run;
  logic [NUM_DIGITS-1:0]   an_lit;
  logic [3:0]              cur_code;
  logic                    cur_dark;
  logic                    dark;

  // Table is stored active-low; polarity is applied once at the output.
  function automatic logic [6:0] glyph_al(input logic [3:0] code);
    case (code)
      4'd0:    glyph_al = 7'b0000001;
      4'd1:    glyph_al = 7'b1001111;
      4'd2:    glyph_al = 7'b0010010;
      4'd3:    glyph_al = 7'b0000110;
      4'd4:    glyph_al = 7'b1001100;
      4'd5:    glyph_al = 7'b0100100;
      4'd6:    glyph_al = 7'b0100000;
      4'd7:    glyph_al = 7'b0001101;
      4'd8:    glyph_al = 7'b0000000;
      4'd9:    glyph_al = 7'b0000100;
      default: glyph_al = 7'b1111110;
    endcase
  endfunction

  always_comb begin
    presc_d = presc_q + 1'b1;
    idx_d   = idx_q;
    if (presc_q == SCAN_W'(SCAN_DIV - 1)) begin
      presc_d = '0;
      idx_d   = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end

    blink_cnt_d = blink_cnt_q + 1'b1;
    phase_d     = phase_q;
    if (!blink_en) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end

    dig_d   = load ? digits_bcd  : dig_q;
    blank_d = load ? blank_mask  : blank_q;
    lz_d    = load ? lz_suppress : lz_q;
  end

  // A digit is a leading zero when it and every more-significant digit are zero; digit 0 is exempt.
  always_comb begin
    lz_dark   = '0;
    zeros_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zeros_run  = zeros_run && (dig_q[4*i +: 4] == 4'd0);
      lz_dark[i] = lz_q && zeros_run;
    end
  end

  always_comb begin
    an_lit   = '0;
    cur_code = 4'd0;
    cur_dark = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        an_lit[i] = 1'b1;
        cur_code  = dig_q[4*i +: 4];
        cur_dark  = blank_q[i] | lz_dark[i];
      end
    end
    dark  = cur_dark | (blink_en & phase_q);
    seg_d = dark ? SEG_OFF : (glyph_al(cur_code) ^ {7{~ACTIVE_LOW}});
    an_d  = dark ? AN_OFF  : (an_lit ^ AN_OFF);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q     <= '0;
      idx_q       <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      dig_q       <= '0;
      blank_q     <= '0;
      lz_q        <= 1'b0;
      seg_q       <= SEG_OFF;
      an_q        <= AN_OFF;
    end else begin
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      dig_q       <= dig_d;
      blank_q     <= blank_d;
      lz_q        <= lz_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule
